// File: rtl/mips_move_top.sv
// Minimal MIPS32-subset SoC: 5-stage in-order core (IF/ID/EX/MEM/WB) with GPR, HI/LO
// and conditional-move support, plus a combinational-read instruction ROM.

module inst_rom #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          ce,
    input  logic [AW-1:0] addr,
    output logic [31:0]   data
);
    logic [31:0] memory [0:DEPTH-1];

    assign data = ce ? memory[addr] : 32'h0;
endmodule

module gpr_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2
);
    logic [31:0] regs [0:31];
    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];

    always_ff @(posedge clk) begin
        if (we && waddr != 5'd0)
            regs[waddr] <= wdata;
    end

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;
    assign rdata1   = rdata[0];
    assign rdata2   = rdata[1];

    // Same-cycle write is bypassed so a reader never sees the stale value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            always_comb begin
                rdata[gi] = 32'h0;
                if (raddr[gi] == 5'd0)
                    rdata[gi] = 32'h0;
                else if (we && waddr == raddr[gi])
                    rdata[gi] = wdata;
                else
                    rdata[gi] = regs[raddr[gi]];
            end
        end
    endgenerate
endmodule

module hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= 32'h0;
            lo <= 32'h0;
        end else begin
            if (we_hi) hi <= wdata;
            if (we_lo) lo <= wdata;
        end
    end
endmodule

module openmips_core #(
    parameter int ROM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       rom_data,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_ce
);
    typedef enum logic [2:0] {
        ALU_NOP, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV, ALU_MFHI, ALU_MFLO
    } alu_op_t;

    logic [31:0] pc;
    logic        ce;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= 32'h0;
            ce <= 1'b0;
        end else begin
            ce <= 1'b1;
            pc <= ce ? pc + 32'd4 : 32'h0;
        end
    end

    assign rom_ce   = ce;
    assign rom_addr = pc[ROM_AW+1:2];

    logic [31:0] id_inst;

    always_ff @(posedge clk) begin
        if (!rst) id_inst <= 32'h0;
        else      id_inst <= rom_data;
    end

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] rf_rdata1, rf_rdata2, rs_val, rt_val;

    assign op    = id_inst[31:26];
    assign rs    = id_inst[25:21];
    assign rt    = id_inst[20:16];
    assign rd    = id_inst[15:11];
    assign imm   = id_inst[15:0];
    assign funct = id_inst[5:0];

    // Pipeline registers downstream of ID, declared early for forwarding.
    alu_op_t     ex_op;
    logic [31:0] ex_a, ex_b, ex_wdata;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whi, ex_wlo;
    logic [31:0] mem_wdata, mem_hilo;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whi, mem_wlo;
    logic [31:0] hi_q, lo_q;

    gpr_file regfile (
        .clk    (clk),
        .we     (mem_wreg & rst),
        .waddr  (mem_wd),
        .wdata  (mem_wdata),
        .raddr1 (rs),
        .rdata1 (rf_rdata1),
        .raddr2 (rt),
        .rdata2 (rf_rdata2)
    );

    always_comb begin
        rs_val = rf_rdata1;
        if (rs == 5'd0)                       rs_val = 32'h0;
        else if (ex_wreg && ex_wd == rs)      rs_val = ex_wdata;
        else if (mem_wreg && mem_wd == rs)    rs_val = mem_wdata;
        rt_val = rf_rdata2;
        if (rt == 5'd0)                       rt_val = 32'h0;
        else if (ex_wreg && ex_wd == rt)      rt_val = ex_wdata;
        else if (mem_wreg && mem_wd == rt)    rt_val = mem_wdata;
    end

    alu_op_t     id_op;
    logic [31:0] id_a, id_b;
    logic [4:0]  id_wd;
    logic        id_wreg, id_whi, id_wlo;

    always_comb begin
        id_op   = ALU_NOP;
        id_a    = 32'h0;
        id_b    = 32'h0;
        id_wd   = 5'd0;
        id_wreg = 1'b0;
        id_whi  = 1'b0;
        id_wlo  = 1'b0;
        case (op)
            6'h0F: begin id_op = ALU_OR; id_a = {imm, 16'h0}; id_wd = rt; id_wreg = 1'b1; end
            6'h0D: begin id_op = ALU_OR; id_a = rs_val; id_b = {16'h0, imm}; id_wd = rt; id_wreg = 1'b1; end
            6'h00: begin
                id_a  = rs_val;
                id_b  = rt_val;
                id_wd = rd;
                case (funct)
                    6'h24: begin id_op = ALU_AND;  id_wreg = 1'b1; end
                    6'h25: begin id_op = ALU_OR;   id_wreg = 1'b1; end
                    6'h26: begin id_op = ALU_XOR;  id_wreg = 1'b1; end
                    // Move conditions are resolved here on forwarded rt.
                    6'h0A: begin id_op = ALU_MOV;  id_wreg = (rt_val == 32'h0); end
                    6'h0B: begin id_op = ALU_MOV;  id_wreg = (rt_val != 32'h0); end
                    6'h10: begin id_op = ALU_MFHI; id_wreg = 1'b1; end
                    6'h12: begin id_op = ALU_MFLO; id_wreg = 1'b1; end
                    6'h11: id_whi = 1'b1;
                    6'h13: id_wlo = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_op   <= ALU_NOP;
            ex_a    <= 32'h0;
            ex_b    <= 32'h0;
            ex_wd   <= 5'd0;
            ex_wreg <= 1'b0;
            ex_whi  <= 1'b0;
            ex_wlo  <= 1'b0;
        end else begin
            ex_op   <= id_op;
            ex_a    <= id_a;
            ex_b    <= id_b;
            ex_wd   <= id_wd;
            ex_wreg <= id_wreg;
            ex_whi  <= id_whi;
            ex_wlo  <= id_wlo;
        end
    end

    // The MEM-stage value is exactly what writes HI/LO at the next edge.
    logic [31:0] hi_cur, lo_cur;
    assign hi_cur = mem_whi ? mem_hilo : hi_q;
    assign lo_cur = mem_wlo ? mem_hilo : lo_q;

    always_comb begin
        ex_wdata = 32'h0;
        case (ex_op)
            ALU_AND:  ex_wdata = ex_a & ex_b;
            ALU_OR:   ex_wdata = ex_a | ex_b;
            ALU_XOR:  ex_wdata = ex_a ^ ex_b;
            ALU_MOV:  ex_wdata = ex_a;
            ALU_MFHI: ex_wdata = hi_cur;
            ALU_MFLO: ex_wdata = lo_cur;
            default:  ex_wdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_wd    <= 5'd0;
            mem_wreg  <= 1'b0;
            mem_wdata <= 32'h0;
            mem_whi   <= 1'b0;
            mem_wlo   <= 1'b0;
            mem_hilo  <= 32'h0;
        end else begin
            mem_wd    <= ex_wd;
            mem_wreg  <= ex_wreg;
            mem_wdata <= ex_wdata;
            mem_whi   <= ex_whi;
            mem_wlo   <= ex_wlo;
            mem_hilo  <= ex_a;
        end
    end

    // No data memory: MEM passes straight through and writeback lands at its closing edge.
    hilo_reg hilo (
        .clk   (clk),
        .rst   (rst),
        .we_hi (mem_whi),
        .we_lo (mem_wlo),
        .wdata (mem_hilo),
        .hi    (hi_q),
        .lo    (lo_q)
    );

    logic unused_bits;
    assign unused_bits = ^{pc[31:ROM_AW+2], pc[1:0], id_inst[10:6]};
endmodule

module mips_move_top #(
    parameter int ROM_DEPTH = 1024,
    parameter int ROM_AW    = 10
) (
    input logic clk,
    input logic rst
);
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              rom_ce;

    openmips_core #(.ROM_AW(ROM_AW)) openmips (
        .clk      (clk),
        .rst      (rst),
        .rom_data (rom_data),
        .rom_addr (rom_addr),
        .rom_ce   (rom_ce)
    );

    inst_rom #(.DEPTH(ROM_DEPTH), .AW(ROM_AW)) rom (
        .ce   (rom_ce),
        .addr (rom_addr),
        .data (rom_data)
    );
endmodule

// File: tb/tb_mips_move_top.sv
// Bench for mips_move_top: fixed move program plus random tail, checked per retirement
// against an instruction-level model, including a mid-program reset.

module tb_mips_move_top;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    mips_move_top #(.ROM_DEPTH(1024), .ROM_AW(10)) dut (
        .clk (clk),
        .rst (rst)
    );

    localparam int NPROG = 64;

    int total = 0;
    int bad   = 0;

    logic [31:0] prog [0:NPROG-1];
    logic [31:0] m_gpr [0:31];
    bit          m_known [0:31];
    logic [31:0] m_hi, m_lo;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] rand_inst();
        int          k;
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        k   = int'($urandom_range(0, 12));
        a   = 5'($urandom_range(0, 4));
        b   = 5'($urandom_range(0, 4));
        c   = 5'($urandom_range(0, 4));
        imm = 16'($urandom);
        case (k)
            0:  return enc_i(6'h0F, 5'd0, a, imm);
            1:  return enc_i(6'h0D, b, a, imm);
            2:  return enc_r(a, b, c, 6'h24);
            3:  return enc_r(a, b, c, 6'h25);
            4:  return enc_r(a, b, c, 6'h26);
            5:  return enc_r(a, b, c, 6'h0A);
            6:  return enc_r(a, b, c, 6'h0B);
            7:  return enc_r(5'd0, 5'd0, c, 6'h10);
            8:  return enc_r(5'd0, 5'd0, c, 6'h12);
            9:  return enc_r(a, 5'd0, 5'd0, 6'h11);
            10: return enc_r(a, 5'd0, 5'd0, 6'h13);
            11: return {6'h23, 26'($urandom)};
            default: return enc_r(a, b, c, 6'h20);
        endcase
    endfunction

    // Architectural interpreter: applies one instruction's effect on retirement.
    task automatic model_step(input logic [31:0] ins);
        logic [5:0]  op, f;
        logic [4:0]  rs, rt, rd;
        logic [31:0] rsv, rtv;
        int          dst;
        logic [31:0] val;
        op  = ins[31:26];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        f   = ins[5:0];
        rsv = (rs == 5'd0) ? 32'h0 : m_gpr[rs];
        rtv = (rt == 5'd0) ? 32'h0 : m_gpr[rt];
        dst = -1;
        val = 32'h0;
        if (op == 6'h0F) begin
            dst = int'(rt); val = {ins[15:0], 16'h0};
        end else if (op == 6'h0D) begin
            dst = int'(rt); val = rsv | {16'h0, ins[15:0]};
        end else if (op == 6'h00) begin
            case (f)
                6'h24: begin dst = int'(rd); val = rsv & rtv; end
                6'h25: begin dst = int'(rd); val = rsv | rtv; end
                6'h26: begin dst = int'(rd); val = rsv ^ rtv; end
                6'h0A: if (rtv == 32'h0) begin dst = int'(rd); val = rsv; end
                6'h0B: if (rtv != 32'h0) begin dst = int'(rd); val = rsv; end
                6'h10: begin dst = int'(rd); val = m_hi; end
                6'h12: begin dst = int'(rd); val = m_lo; end
                6'h11: m_hi = rsv;
                6'h13: m_lo = rsv;
                default: ;
            endcase
        end
        if (dst > 0) begin
            m_gpr[dst]   = val;
            m_known[dst] = 1'b1;
        end
    endtask

    task automatic check_state(input string ph, input int e);
        for (int r = 1; r <= 4; r++) begin
            if (m_known[r])
                check_val($sformatf("%s e%0d r%0d", ph, e, r), dut.openmips.regfile.regs[r], m_gpr[r]);
        end
        check_val($sformatf("%s e%0d hi", ph, e), dut.openmips.hilo.hi, m_hi);
        check_val($sformatf("%s e%0d lo", ph, e), dut.openmips.hilo.lo, m_lo);
    endtask

    // Releases reset and runs the program; stop_at>0 re-asserts reset after that edge.
    task automatic run(input string ph, input int stop_at);
        m_hi = 32'h0;
        m_lo = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        for (int e = 1; e <= NPROG + 8; e++) begin
            @(negedge clk);
            if (e >= 5 && e - 5 < NPROG)
                model_step(prog[e-5]);
            check_val($sformatf("%s e%0d pc", ph, e), dut.openmips.pc, 32'(4 * (e - 1)));
            check_val($sformatf("%s e%0d ce", ph, e), {31'h0, dut.openmips.ce}, 32'h1);
            check_state(ph, e);
            $display("%s edge %0d pc=%h hi=%h lo=%h", ph, e, dut.openmips.pc, m_hi, m_lo);
            if (e == stop_at) begin
                rst = 1'b0;
                @(negedge clk);
                m_hi = 32'h0;
                m_lo = 32'h0;
                check_val($sformatf("%s rst pc", ph), dut.openmips.pc, 32'h0);
                check_val($sformatf("%s rst ce", ph), {31'h0, dut.openmips.ce}, 32'h0);
                check_state($sformatf("%s rst", ph), e);
                $display("%s reset asserted after edge %0d", ph, e);
                repeat (2) @(negedge clk);
                return;
            end
        end
    endtask

    initial begin
        prog[0]  = enc_i(6'h0F, 5'd0, 5'd1, 16'h0000);
        prog[1]  = enc_i(6'h0F, 5'd0, 5'd2, 16'hFFFF);
        prog[2]  = enc_i(6'h0F, 5'd0, 5'd3, 16'h0505);
        prog[3]  = enc_i(6'h0F, 5'd0, 5'd4, 16'h0000);
        prog[4]  = enc_r(5'd2, 5'd1, 5'd4, 6'h0A);
        prog[5]  = enc_r(5'd3, 5'd1, 5'd4, 6'h0B);
        prog[6]  = enc_r(5'd3, 5'd2, 5'd4, 6'h0B);
        prog[7]  = enc_r(5'd2, 5'd3, 5'd4, 6'h0A);
        prog[8]  = enc_r(5'd0, 5'd0, 5'd0, 6'h11);
        prog[9]  = enc_r(5'd2, 5'd0, 5'd0, 6'h11);
        prog[10] = enc_r(5'd3, 5'd0, 5'd0, 6'h11);
        prog[11] = enc_r(5'd0, 5'd0, 5'd4, 6'h10);
        prog[12] = enc_r(5'd3, 5'd0, 5'd0, 6'h13);
        prog[13] = enc_r(5'd2, 5'd0, 5'd0, 6'h13);
        prog[14] = enc_r(5'd1, 5'd0, 5'd0, 6'h13);
        prog[15] = enc_r(5'd0, 5'd0, 5'd4, 6'h12);
        for (int i = 16; i < NPROG; i++)
            prog[i] = rand_inst();

        for (int i = 0; i < 1024; i++)
            dut.rom.memory[i] = 32'h0;
        for (int i = 0; i < NPROG; i++)
            dut.rom.memory[i] = prog[i];

        for (int r = 0; r < 32; r++) begin
            m_gpr[r]   = 32'h0;
            m_known[r] = (r == 0);
        end

        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_val("reset pc", dut.openmips.pc, 32'h0);
        check_val("reset ce", {31'h0, dut.openmips.ce}, 32'h0);
        check_val("reset hi", dut.openmips.hilo.hi, 32'h0);
        check_val("reset lo", dut.openmips.hilo.lo, 32'h0);

        run("p1", 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run("p2", int'($urandom_range(8, 60)));
        run("p3", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mips_move_top.md
Name: mips_move_top

Overview:
- Minimal MIPS32-subset SoC top: a 5-stage in-order pipelined core (IF, ID, EX, MEM, WB) plus an instruction ROM.
- Executes a straight-line program from address 0.
- Exercises the GPR file, the HI/LO registers and the conditional/special move instructions.
- No data memory, branches, stalls or exceptions.

Parameters:
- ROM_DEPTH, 1024, instruction ROM depth in 32-bit words.
- ROM_AW, 10, ROM word-address width, equal to log2(ROM_DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.

Behaviour:
- Hierarchy is fixed for bench backdoor access:
  - ROM array: rom.memory[0:ROM_DEPTH-1], 32 bit, loadable by $readmemh.
  - GPR array: openmips.regfile.regs[0:31].
  - HI/LO registers: openmips.hilo.hi and openmips.hilo.lo.
- Reset (rst=0 at a rising edge):
  - PC=0; fetch enable ce=0.
  - All pipeline registers cleared to NOP: no write-enable, zero data.
  - HI=0, LO=0.
  - GPRs 1..31 are not reset and power up X; regs[0] always reads 0.
- Fetch:
  - ce <= 1 on the first edge with rst=1. PC holds 0 while ce=0, then PC += 4 each cycle.
  - ROM read is combinational at word index pc[ROM_AW+1:2] and returns 0 (NOP) while ce=0.
  - No wrap handling beyond the natural ROM_AW truncation.
- Timing:
  - Instruction 0's write is visible after the 5th rising edge that samples rst=1.
  - Each following instruction retires exactly one cycle later. No stalls.
- Register file:
  - Two combinational read ports; write in WB on the rising edge.
  - A read of the register being written in the same cycle returns the new value.
  - Writes to r0 are ignored.
- GPR forwarding into ID, priority EX result over MEM result over regfile.
- HI/LO:
  - Written in WB on the rising edge.
  - EX-stage reads of HI/LO forward, priority MEM over WB over the registers.
  - MTHI writes HI only and MTLO writes LO only; the other register is preserved.
- Supported instructions; every other encoding is a NOP:
  - LUI (op 0x0F): rt = {imm16, 16'h0}.
  - ORI (op 0x0D): rt = rs | zero_ext(imm16).
  - SPECIAL (op 0x00), rd = rs OP rt: AND funct 0x24, OR funct 0x25, XOR funct 0x26.
  - MOVZ (funct 0x0A): if rt==0 then rd = rs, else no write.
  - MOVN (funct 0x0B): if rt!=0 then rd = rs, else no write.
  - MFHI (funct 0x10): rd = HI. MFLO (funct 0x12): rd = LO.
  - MTHI (funct 0x11): HI = rs. MTLO (funct 0x13): LO = rs.
- MOVZ/MOVN conditions use forwarded operand values. A false condition deasserts the GPR write-enable, so the destination is unchanged.
- Reset asserted mid-program: the pipeline flushes to NOP, PC returns to 0 and HI/LO return to 0. GPRs keep their values.

Test Plan:
- ROM program (16 words): lui $1,0; lui $2,0xFFFF; lui $3,0x0505; lui $4,0; movz $4,$2,$1; movn $4,$3,$1; movn $4,$3,$2; movz $4,$2,$3; mthi $0; mthi $2; mthi $3; mfhi $4; mtlo $3; mtlo $2; mtlo $1; mflo $4. Hold rst=0 for 10 cycles, then release.
- Back-to-back LUIs -> r1=0, then r2=FFFF0000, r3=05050000, r4=0, one per cycle starting 5 edges after reset release. HI=LO=0 throughout.
- Conditional moves -> r4 sequence: FFFF0000 (movz taken), unchanged (movn not taken), 05050000 (movn taken), unchanged (movz not taken).
- HI path with forwarding -> HI: 0, FFFF0000, 05050000. The following mfhi gives r4=05050000.
- LO path -> LO: 05050000, FFFF0000, 00000000. The following mflo gives r4=0; r1..r3 unchanged.
- Reset re-assertion mid-program -> next edge HI=LO=0 and PC=0; the program restarts and reproduces the same sequence.
